// File: rtl/can_tx_block.sv
// can_tx_block: CAN 2.0A base-frame transmitter (11-bit ID, DLC fixed at 8).
// Bit stuffing covers SOF through the last CRC bit; CRC-15 covers the data field only.
// Optional build macro CAN_TX_ACK_CHECK_EN: checks the ACK slot on can_rx and drives ack_err.
`timescale 1ns/1ps
module can_tx_block #(
  parameter int unsigned CLKS_PER_BIT = 16,
  parameter logic [14:0] CRC_POLY     = 15'h4599
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [10:0] address_tx,
  input  logic [63:0] tx_data,
  input  logic        tx_start,
  input  logic        can_rx,
  output logic        can_tx,
  output logic        txing,
  output logic        tx_done,
  output logic        ack_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_START, S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA,
    S_CRC, S_CRC_DEL, S_ACK, S_ACK_DEL, S_EOF, S_IFS
  } state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state;
  state_t      nxt_state;
  logic [6:0]  bit_cnt;
  logic [6:0]  nxt_cnt;
  logic [15:0] baud_cnt;
  logic [10:0] id_sh;
  logic [63:0] data_sh;
  logic [14:0] crc;
  logic        last_lvl;
  logic [2:0]  run_len;
  logic        nxt_bit;
  logic        frame_end;
  logic        bit_tick;
  logic        accept;
  logic        need_stuff;

  // One serial CRC-15 step for a single unstuffed data bit.
  function automatic logic [14:0] crc_step(input logic [14:0] c, input logic d);
    logic fb;
    fb = d ^ c[14];
    return {c[13:0], 1'b0} ^ (fb ? CRC_POLY : 15'd0);
  endfunction

  assign bit_tick   = (baud_cnt == BAUD_LAST);
  assign accept     = (state == S_IDLE) && tx_start;
  // A stuff bit is owed once five equal levels have gone out inside SOF..CRC.
  assign need_stuff = (state inside {S_SOF, S_ID, S_RTR, S_IDE, S_R0, S_DLC, S_DATA, S_CRC})
                      && (run_len == 3'd5);

  // Next payload position: state and per-state bit index after the current payload bit.
  always_comb begin
    nxt_state = state;
    nxt_cnt   = bit_cnt + 7'd1;
    frame_end = 1'b0;
    case (state)
      S_SOF:     begin nxt_state = S_ID;      nxt_cnt = 7'd0; end
      S_ID:      if (bit_cnt == 7'd10) begin nxt_state = S_RTR;     nxt_cnt = 7'd0; end
      S_RTR:     begin nxt_state = S_IDE;     nxt_cnt = 7'd0; end
      S_IDE:     begin nxt_state = S_R0;      nxt_cnt = 7'd0; end
      S_R0:      begin nxt_state = S_DLC;     nxt_cnt = 7'd0; end
      S_DLC:     if (bit_cnt == 7'd3)  begin nxt_state = S_DATA;    nxt_cnt = 7'd0; end
      S_DATA:    if (bit_cnt == 7'd63) begin nxt_state = S_CRC;     nxt_cnt = 7'd0; end
      S_CRC:     if (bit_cnt == 7'd14) begin nxt_state = S_CRC_DEL; nxt_cnt = 7'd0; end
      S_CRC_DEL: begin nxt_state = S_ACK;     nxt_cnt = 7'd0; end
      S_ACK:     begin nxt_state = S_ACK_DEL; nxt_cnt = 7'd0; end
      S_ACK_DEL: begin nxt_state = S_EOF;     nxt_cnt = 7'd0; end
      S_EOF:     if (bit_cnt == 7'd6)  begin nxt_state = S_IFS;     nxt_cnt = 7'd0; end
      S_IFS:     if (bit_cnt == 7'd2)  begin nxt_state = S_IDLE; nxt_cnt = 7'd0; frame_end = 1'b1; end
      default:   begin nxt_state = state; nxt_cnt = bit_cnt; end
    endcase
  end

  // Bus level for the payload bit at the next position (DLC is fixed 4'b1000).
  always_comb begin
    nxt_bit = 1'b1;
    case (nxt_state)
      S_SOF, S_RTR, S_IDE, S_R0: nxt_bit = 1'b0;
      S_ID:                      nxt_bit = id_sh[10];
      S_DLC:                     nxt_bit = (nxt_cnt == 7'd0);
      S_DATA:                    nxt_bit = data_sh[63];
      S_CRC:                     nxt_bit = crc[14];
      default:                   nxt_bit = 1'b1;
    endcase
  end

  // Payload holding registers: loaded on acceptance, shifted as each payload bit is sent.
  always_ff @(posedge clk) begin
    if (accept) begin
      id_sh   <= address_tx;
      data_sh <= tx_data;
    end else if (txing && bit_tick && !need_stuff) begin
      if (nxt_state == S_ID)   id_sh   <= {id_sh[9:0], 1'b0};
      if (nxt_state == S_DATA) data_sh <= {data_sh[62:0], 1'b0};
    end
  end

  // Frame sequencer: baud timer, stuffing, CRC and registered bus outputs.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= S_IDLE;
      bit_cnt  <= 7'd0;
      baud_cnt <= 16'd0;
      crc      <= 15'd0;
      last_lvl <= 1'b1;
      run_len  <= 3'd0;
      can_tx   <= 1'b1;
      txing    <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;
      if (accept) begin
        state    <= S_START;
        baud_cnt <= 16'd0;
      end else if (state == S_START) begin
        state    <= S_SOF;
        bit_cnt  <= 7'd0;
        baud_cnt <= 16'd0;
        crc      <= 15'd0;
        last_lvl <= 1'b0;
        run_len  <= 3'd1;
        can_tx   <= 1'b0;
        txing    <= 1'b1;
      end else if (txing) begin
        if (!bit_tick) begin
          baud_cnt <= baud_cnt + 16'd1;
        end else begin
          baud_cnt <= 16'd0;
          if (need_stuff) begin
            can_tx   <= ~last_lvl;
            last_lvl <= ~last_lvl;
            run_len  <= 3'd1;
          end else begin
            state    <= nxt_state;
            bit_cnt  <= nxt_cnt;
            can_tx   <= nxt_bit;
            last_lvl <= nxt_bit;
            run_len  <= (nxt_bit == last_lvl) ? run_len + 3'd1 : 3'd1;
            if (nxt_state == S_DATA) crc <= crc_step(crc, nxt_bit);
            if (nxt_state == S_CRC)  crc <= {crc[13:0], 1'b0};
            if (frame_end) begin
              txing   <= 1'b0;
              tx_done <= 1'b1;
            end
          end
        end
      end
    end
  end

`ifdef CAN_TX_ACK_CHECK_EN
  localparam logic [15:0] BAUD_MID = 16'(CLKS_PER_BIT / 2);

  // Sticky ACK failure: recessive readback at mid-bit of the ACK slot.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ack_err <= 1'b0;
    end else if (accept) begin
      ack_err <= 1'b0;
    end else if ((state == S_ACK) && (baud_cnt == BAUD_MID) && can_rx) begin
      ack_err <= 1'b1;
    end
  end
`else
  logic unused_can_rx;
  assign unused_can_rx = can_rx;
  assign ack_err       = 1'b0;
`endif

endmodule

// File: tb/tb_can_tx_block.sv
// tb_can_tx_block: scoreboard bench for can_tx_block with CLKS_PER_BIT = 4.
`timescale 1ns/1ps
module tb_can_tx_block;

  localparam int CPB = 4;

  logic        clk;
  logic        rst;
  logic [10:0] address_tx;
  logic [63:0] tx_data;
  logic        tx_start;
  logic        can_rx;
  logic        can_tx;
  logic        txing;
  logic        tx_done;
  logic        ack_err;

  int n_checks = 0;
  int n_fail   = 0;

  logic         exp_q[$];
  logic         got[$];
  logic [110:0] exp_u;
  int           exp_len;

  can_tx_block #(.CLKS_PER_BIT(CPB), .CRC_POLY(15'h4599)) dut (
    .clk(clk), .rst(rst), .address_tx(address_tx), .tx_data(tx_data),
    .tx_start(tx_start), .can_rx(can_rx), .can_tx(can_tx), .txing(txing),
    .tx_done(tx_done), .ack_err(ack_err)
  );

  always #5 clk = ~clk;

  function automatic logic [14:0] model_crc(input logic [63:0] d);
    logic [14:0] r;
    logic        top;
    r = 15'd0;
    for (int i = 63; i >= 0; i--) begin
      top = r[14];
      r   = r << 1;
      if (top != d[i]) r = r ^ 15'h4599;
    end
    return r;
  endfunction

  // Build the unstuffed frame, stuff it, and push the expected bus bits.
  task automatic build_model(input logic [10:0] id, input logic [63:0] d);
    int   run;
    logic last;
    logic b;
    exp_q.delete();
    exp_u = {1'b0, id, 3'b000, 4'b1000, d, model_crc(d), 3'b111, 7'h7F, 3'b111};
    run  = 0;
    last = 1'b1;
    for (int i = 0; i < 111; i++) begin
      b = exp_u[110 - i];
      if (i <= 98 && run == 5) begin
        exp_q.push_back(~last);
        last = ~last;
        run  = 1;
      end
      if (i < 98) begin
        if (run > 0 && b == last) run++;
        else run = 1;
        last = b;
      end
      exp_q.push_back(b);
    end
    exp_len = exp_q.size();
  endtask

  // Called at a negedge; returns #1 after the acceptance edge.
  task automatic start_frame(input logic [10:0] id, input logic [63:0] d, input bit push);
    if (push) build_model(id, d);
    address_tx = id;
    tx_data    = d;
    tx_start   = 1'b1;
    @(posedge clk);
    #1;
    tx_start   = 1'b0;
    address_tx = ~id;
    tx_data    = ~d;
    n_checks++;
    if (txing !== 1'b0) begin
      n_fail++;
      $display("FAIL accept_edge_txing: got %b, expected 0", txing);
    end
  endtask

  // Follow one frame to tx_done, comparing each mid-bit sample with the scoreboard.
  task automatic drain(input string name, input int poke_t);
    int   t;
    int   clks;
    int   first_tx;
    bit   seen_done;
    logic e;
    got.delete();
    t = 0; clks = 0; first_tx = -1; seen_done = 0;
    @(posedge clk);
    while (!seen_done && t < 4000) begin
      @(negedge clk);
      tx_start = (t == poke_t);
      if (txing) begin
        clks++;
        if (first_tx < 0) first_tx = t;
      end
      if (tx_done) seen_done = 1;
      if (txing && (t % CPB) == 1) begin
        got.push_back(can_tx);
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL %s extra_bit %0d: got %b, expected no bit", name, got.size() - 1, can_tx);
        end else begin
          e = exp_q.pop_front();
          if (can_tx !== e) begin
            n_fail++;
            $display("FAIL %s bit %0d: got %b, expected %b", name, got.size() - 1, can_tx, e);
          end
        end
      end
      t++;
    end
    tx_start = 1'b0;
    n_checks++;
    if (!seen_done) begin
      n_fail++;
      $display("FAIL %s tx_done_timeout: got no pulse in %0d clks, expected one", name, t);
    end
    n_checks++;
    if (first_tx != 0) begin
      n_fail++;
      $display("FAIL %s sof_latency: got txing first at %0d, expected 0", name, first_tx);
    end
    n_checks++;
    if (clks != exp_len * CPB) begin
      n_fail++;
      $display("FAIL %s txing_clks: got %0d, expected %0d", name, clks, exp_len * CPB);
    end
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL %s missing_bits: got %0d left, expected 0", name, exp_q.size());
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_checks++;
    if ({can_tx, txing, tx_done, ack_err} !== 4'b1000) begin
      n_fail++;
      $display("FAIL reset_outputs: got can_tx,txing,tx_done,ack_err=%b, expected 1000",
               {can_tx, txing, tx_done, ack_err});
    end
    tx_start = 1'b1;
    @(negedge clk);
    tx_start = 1'b0;
    rst      = 1'b0;
    repeat (4) @(negedge clk);
    n_checks++;
    if (txing !== 1'b0 || can_tx !== 1'b1) begin
      n_fail++;
      $display("FAIL start_during_reset: got txing=%b can_tx=%b, expected 0 1", txing, can_tx);
    end
  endtask

  task automatic test_stuffing();
    logic [11:0] pre;
    start_frame(11'h000, 64'h0, 1);
    drain("stuff_zero", -1);
    for (int i = 0; i < 12; i++) pre[11 - i] = (i < got.size()) ? got[i] : 1'bx;
    n_checks++;
    if (pre !== 12'b000001000001) begin
      n_fail++;
      $display("FAIL stuff_prefix: got %b, expected 000001000001", pre);
    end
  endtask

  task automatic test_known_frame();
    logic [82:0] gp;
    start_frame(11'h555, 64'hA5A5_A5A5_A5A5_A5A5, 1);
    drain("known", -1);
    for (int i = 0; i < 83; i++) gp[82 - i] = (i < got.size()) ? got[i] : 1'bx;
    n_checks++;
    if (gp !== exp_u[110 -: 83]) begin
      n_fail++;
      $display("FAIL known_unstuffed_head: got %h, expected %h", gp, exp_u[110 -: 83]);
    end
    @(negedge clk);
    n_checks++;
    if (tx_done !== 1'b0) begin
      n_fail++;
      $display("FAIL tx_done_single: got %b a clk later, expected 0", tx_done);
    end
  endtask

  task automatic test_latency_busy();
    bit quiet;
    start_frame(11'h123, {$urandom, $urandom}, 1);
    drain("busy", 20);
    quiet = 1;
    repeat (12) begin
      @(negedge clk);
      if (txing !== 1'b0 || can_tx !== 1'b1) quiet = 0;
    end
    n_checks++;
    if (!quiet) begin
      n_fail++;
      $display("FAIL busy_no_queue: got a second frame, expected none");
    end
  endtask

  task automatic test_back_to_back();
    bit ones;
    start_frame(11'h7F0, 64'hFFFF_0000_1234_5678, 1);
    drain("b2b_first", -1);
    ones = (got.size() >= 10);
    for (int i = 0; i < 10 && i < got.size(); i++)
      if (got[got.size() - 1 - i] !== 1'b1) ones = 0;
    n_checks++;
    if (!ones) begin
      n_fail++;
      $display("FAIL b2b_eof_ifs: got trailing bits not all recessive, expected 10 ones");
    end
    start_frame(11'h00F, 64'h0F0F_F0F0_0000_FFFF, 1);
    drain("b2b_second", -1);
  endtask

  task automatic test_reset_midframe();
    bit idle;
    start_frame(11'h555, 64'hA5A5_A5A5_A5A5_A5A5, 0);
    repeat (160) @(negedge clk);
    rst = 1'b1;
    #1;
    n_checks++;
    if (can_tx !== 1'b1 || txing !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_reset: got can_tx=%b txing=%b, expected 1 0", can_tx, txing);
    end
    repeat (2) @(negedge clk);
    rst  = 1'b0;
    idle = 1;
    repeat (10) begin
      @(negedge clk);
      if (txing !== 1'b0 || can_tx !== 1'b1) idle = 0;
    end
    n_checks++;
    if (!idle) begin
      n_fail++;
      $display("FAIL post_reset_idle: got activity, expected idle");
    end
    start_frame(11'h2AB, 64'hDEAD_BEEF_CAFE_F00D, 1);
    drain("after_reset", -1);
  endtask

  task automatic test_random();
    for (int k = 0; k < 2; k++) begin
      start_frame(11'($urandom), {$urandom, $urandom}, 1);
      drain("random", -1);
    end
  endtask

  task automatic test_ack();
`ifdef CAN_TX_ACK_CHECK_EN
    can_rx = 1'b1;
    start_frame(11'h111, 64'h0123_4567_89AB_CDEF, 1);
    drain("ack_missing", -1);
    n_checks++;
    if (ack_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_err_set: got %b, expected 1", ack_err);
    end
    repeat (5) @(negedge clk);
    n_checks++;
    if (ack_err !== 1'b1) begin
      n_fail++;
      $display("FAIL ack_err_sticky: got %b, expected 1", ack_err);
    end
    can_rx = 1'b0;
    start_frame(11'h222, 64'hFEDC_BA98_7654_3210, 1);
    n_checks++;
    if (ack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_err_clear: got %b, expected 0", ack_err);
    end
    drain("ack_ok", -1);
    n_checks++;
    if (ack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_err_stays_clear: got %b, expected 0", ack_err);
    end
    can_rx = 1'b1;
`else
    can_rx = 1'b1;
    start_frame(11'h111, 64'h0123_4567_89AB_CDEF, 1);
    drain("ack_off", -1);
    n_checks++;
    if (ack_err !== 1'b0) begin
      n_fail++;
      $display("FAIL ack_err_tied: got %b, expected 0", ack_err);
    end
`endif
  endtask

  initial begin
    clk        = 1'b0;
    rst        = 1'b1;
    tx_start   = 1'b0;
    can_rx     = 1'b1;
    address_tx = 11'd0;
    tx_data    = 64'd0;
    test_reset();
    test_stuffing();
    test_known_frame();
    test_latency_busy();
    test_back_to_back();
    test_reset_midframe();
    test_random();
    test_ack();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
